// File: rtl/bin_vote_pkg.sv
// Shared types and helpers for the bin vote detector.
// Class codes: 0 = silence, i+1 = bin i dominant.
package bin_vote_pkg;

    localparam int unsigned CLS_SILENCE = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        REARM = 2'd2
    } hit_state_e;

    // Width of a class code able to hold 0..n.
    function automatic int unsigned cls_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bin_vote_detector_vote_window.sv
// Sliding vote window: FIFO of the last WINDOW class codes, one running count
// per class, a saturating fill counter and the registered majority decision.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   push            class code on cls is pushed into the window this cycle
//   cls             class code to push
//   overall_result  lowest-index bin with count >= VOTE_THRESH, 0 if none/not full
//   window_full     WINDOW frames collected since reset
module vote_window
    import bin_vote_pkg::*;
#(
    parameter int unsigned  NUM_BINS    = 4,
    parameter int unsigned  WINDOW      = 16,
    parameter int unsigned  VOTE_THRESH = 8,
    localparam int unsigned CLS_W       = cls_width(NUM_BINS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [CLS_W-1:0] cls,
    output logic [CLS_W-1:0] overall_result,
    output logic             window_full
);

    localparam int unsigned CNT_W   = $clog2(WINDOW + 1);
    localparam int unsigned NUM_CLS = NUM_BINS + 1;

    logic [CLS_W-1:0] fifo     [WINDOW];
    logic [CNT_W-1:0] cnt      [NUM_CLS];
    logic [CNT_W-1:0] cnt_next [NUM_CLS];
    logic [CNT_W-1:0] fill;
    logic [CNT_W-1:0] fill_next;
    logic [CLS_W-1:0] decision_c;

    // Count update: +1 for the incoming class, -1 for the evicted one once full.
    // Equal classes cancel; modular arithmetic keeps a transient overflow harmless.
    always_comb begin
        for (int k = 0; k < int'(NUM_CLS); k++) begin
            cnt_next[k] = cnt[k];
            if (push) begin
                if (cls == CLS_W'(k)) begin
                    cnt_next[k] = cnt_next[k] + CNT_W'(1);
                end
                if (window_full && (fifo[WINDOW-1] == CLS_W'(k))) begin
                    cnt_next[k] = cnt_next[k] - CNT_W'(1);
                end
            end
        end
        fill_next = (fill == CNT_W'(WINDOW)) ? fill : fill + CNT_W'(1);
    end

    // Decision: scan high to low so the lowest qualifying bin wins ties.
    always_comb begin
        decision_c = CLS_W'(CLS_SILENCE);
        for (int k = int'(NUM_BINS); k >= 1; k--) begin
            if (cnt[k] >= CNT_W'(VOTE_THRESH)) begin
                decision_c = CLS_W'(k);
            end
        end
        if (!window_full) begin
            decision_c = CLS_W'(CLS_SILENCE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(WINDOW); i++) begin
                fifo[i] <= '0;
            end
            for (int k = 0; k < int'(NUM_CLS); k++) begin
                cnt[k] <= '0;
            end
            fill           <= '0;
            window_full    <= 1'b0;
            overall_result <= '0;
        end else begin
            if (push) begin
                fifo[0] <= cls;
                for (int i = 1; i < int'(WINDOW); i++) begin
                    fifo[i] <= fifo[i-1];
                end
                fill        <= fill_next;
                window_full <= (fill_next == CNT_W'(WINDOW));
            end
            for (int k = 0; k < int'(NUM_CLS); k++) begin
                cnt[k] <= cnt_next[k];
            end
            overall_result <= decision_c;
        end
    end

endmodule

// File: rtl/bin_vote_detector.sv
// N-bin tone detector: per-frame dominant-bin classifier, windowed majority
// vote and an onset FSM emitting one hit pulse per struck note with hold-off.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   advance         one-cycle strobe, power words valid this cycle
//   power           signed bin powers, index 0..NUM_BINS-1
//   result          per-frame class (0 silence, i+1 = bin i), held between strobes
//   overall_result  windowed vote decision, same encoding
//   window_full     WINDOW frames collected since reset
//   hit_valid       one-cycle onset pulse
//   hit_bin         class of the last hit, held until the next one
module bin_vote_detector
    import bin_vote_pkg::*;
#(
    parameter int unsigned  NUM_BINS    = 4,
    parameter int unsigned  POWER_WIDTH = 64,
    parameter int unsigned  SHIFT_LOG2  = 3,
    parameter int unsigned  WINDOW      = 16,
    parameter int unsigned  VOTE_THRESH = 8,
    parameter int unsigned  HOLDOFF     = 32,
    localparam int unsigned CLS_W       = cls_width(NUM_BINS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          advance,
    input  logic signed [POWER_WIDTH-1:0] power [NUM_BINS],
    output logic        [CLS_W-1:0]       result,
    output logic        [CLS_W-1:0]       overall_result,
    output logic                          window_full,
    output logic                          hit_valid,
    output logic        [CLS_W-1:0]       hit_bin
);

    localparam int unsigned HOLD_W = $clog2(HOLDOFF + 1);

    logic [NUM_BINS-1:0] dom_c;
    logic [CLS_W-1:0]    cls_c;
    logic                push_q1;
    logic                push_q2;
    logic                push_q3;

    hit_state_e          state;
    hit_state_e          state_next;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_next;
    logic                fire_c;
    logic [CLS_W-1:0]    hit_bin_next;

    // Classifier: bin i wins only if its power, shifted down by the margin,
    // still beats every other bin (signed compare). At most one can win.
    always_comb begin
        dom_c = '1;
        cls_c = CLS_W'(CLS_SILENCE);
        for (int i = 0; i < int'(NUM_BINS); i++) begin
            for (int j = 0; j < int'(NUM_BINS); j++) begin
                if ((j != i) && !((power[i] >>> SHIFT_LOG2) > power[j])) begin
                    dom_c[i] = 1'b0;
                end
            end
            if (dom_c[i]) begin
                cls_c = CLS_W'(i + 1);
            end
        end
    end

    // Result register and strobe pipe; push_q3 marks the cycle overall_result
    // first reflects a pushed frame, which is what the hold counter counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            result  <= '0;
            push_q1 <= 1'b0;
            push_q2 <= 1'b0;
            push_q3 <= 1'b0;
        end else begin
            push_q1 <= advance;
            push_q2 <= push_q1;
            push_q3 <= push_q2;
            if (advance) begin
                result <= cls_c;
            end
        end
    end

    vote_window #(
        .NUM_BINS    (NUM_BINS),
        .WINDOW      (WINDOW),
        .VOTE_THRESH (VOTE_THRESH)
    ) u_window (
        .clk            (clk),
        .reset          (reset),
        .push           (push_q1),
        .cls            (result),
        .overall_result (overall_result),
        .window_full    (window_full)
    );

    // Hit FSM state register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            hit_valid <= 1'b0;
            hit_bin   <= '0;
        end else begin
            state     <= state_next;
            hold_cnt  <= hold_next;
            hit_valid <= fire_c;
            hit_bin   <= hit_bin_next;
        end
    end

    // Hit FSM next state. A fire always lands in HOLD, so two hits can never
    // be adjacent; REARM only retriggers on a different bin.
    always_comb begin
        state_next   = state;
        hold_next    = hold_cnt;
        fire_c       = 1'b0;
        hit_bin_next = hit_bin;
        unique case (state)
            IDLE: begin
                if (overall_result != CLS_W'(CLS_SILENCE)) begin
                    fire_c = 1'b1;
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_next = REARM;
                end else if (push_q3) begin
                    hold_next = hold_cnt - HOLD_W'(1);
                    if (hold_cnt == HOLD_W'(1)) begin
                        state_next = REARM;
                    end
                end
            end
            REARM: begin
                if (overall_result == CLS_W'(CLS_SILENCE)) begin
                    state_next = IDLE;
                end else if (overall_result != hit_bin) begin
                    fire_c = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (fire_c) begin
            hit_bin_next = overall_result;
            hold_next    = HOLD_W'(HOLDOFF);
            state_next   = HOLD;
        end
    end

endmodule

// File: tb/tb_bin_vote_detector.sv
// Scoreboard bench for bin_vote_detector (default parameters).
module tb_bin_vote_detector;
    import bin_vote_pkg::*;

    localparam int unsigned NUM_BINS    = 4;
    localparam int unsigned POWER_WIDTH = 64;
    localparam int unsigned WINDOW      = 16;
    localparam int unsigned VOTE_THRESH = 8;
    localparam int unsigned HOLDOFF     = 32;
    localparam int unsigned CLS_W       = cls_width(NUM_BINS);
    localparam int          GAP         = 6;

    logic                          clk = 1'b0;
    logic                          reset;
    logic                          advance;
    logic signed [POWER_WIDTH-1:0] power [NUM_BINS];
    logic [CLS_W-1:0]              result;
    logic [CLS_W-1:0]              overall_result;
    logic                          window_full;
    logic                          hit_valid;
    logic [CLS_W-1:0]              hit_bin;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int hits_seen   = 0;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    exp_t res_q[$];
    exp_t hit_q[$];

    // Frame-level reference model
    int win_q[$];
    int m_state;      // 0 idle, 1 holding, 2 rearmed
    int m_cnt;
    int m_hb;
    int m_last_cls;

    bin_vote_detector #(
        .NUM_BINS    (NUM_BINS),
        .POWER_WIDTH (POWER_WIDTH),
        .SHIFT_LOG2  (3),
        .WINDOW      (WINDOW),
        .VOTE_THRESH (VOTE_THRESH),
        .HOLDOFF     (HOLDOFF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .advance        (advance),
        .power          (power),
        .result         (result),
        .overall_result (overall_result),
        .window_full    (window_full),
        .hit_valid      (hit_valid),
        .hit_bin        (hit_bin)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int model_decision();
        int c [NUM_BINS+1];
        foreach (c[k]) c[k] = 0;
        if (win_q.size() != int'(WINDOW)) return 0;
        foreach (win_q[i]) c[win_q[i]]++;
        for (int k = 1; k <= int'(NUM_BINS); k++) begin
            if (c[k] >= int'(VOTE_THRESH)) return k;
        end
        return 0;
    endfunction

    task automatic model_fire(input int d, input int at);
        hit_q.push_back('{at, d});
        m_hb    = d;
        m_state = 1;
        m_cnt   = HOLDOFF;
    endtask

    task automatic model_rearm(input int d, input int at);
        if (d == 0) m_state = 0;
        else if (d != m_hb) model_fire(d, at);
    endtask

    // t = cycle in which advance is high for this frame
    task automatic model_push(input int cls, input int t);
        int d;
        win_q.push_back(cls);
        if (win_q.size() > int'(WINDOW)) void'(win_q.pop_front());
        d = model_decision();
        case (m_state)
            0: if (d != 0) model_fire(d, t + 4);
            1: begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_state = 2;
                    model_rearm(d, t + 5);
                end
            end
            default: model_rearm(d, t + 4);
        endcase
        m_last_cls = cls;
    endtask

    task automatic check_state();
        check_eq("overall_result", 64'(overall_result), 64'(model_decision()));
        check_eq("window_full", 64'(window_full), 64'(win_q.size() == int'(WINDOW)));
        check_eq("result_hold", 64'(result), 64'(m_last_cls));
    endtask

    // One strobe; gap > 0 idles that many cycles and then checks steady state.
    task automatic frame(input longint p0, input longint p1, input longint p2,
                         input longint p3, input int exp_cls, input int gap);
        @(negedge clk);
        power[0] = p0;
        power[1] = p1;
        power[2] = p2;
        power[3] = p3;
        advance  = 1'b1;
        res_q.push_back('{cyc + 1, exp_cls});
        model_push(exp_cls, cyc);
        if (gap > 0) begin
            @(negedge clk);
            advance = 1'b0;
            repeat (gap - 1) @(negedge clk);
            check_state();
        end
    endtask

    task automatic tone(input int b, input int n, input int gap);
        longint p [4];
        for (int r = 0; r < n; r++) begin
            foreach (p[i]) p[i] = (i == b) ? 1000 : 100;
            frame(p[0], p[1], p[2], p[3], b + 1, gap);
        end
    endtask

    task automatic silence(input int n);
        for (int r = 0; r < n; r++) frame(100, 100, 100, 100, 0, GAP);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        advance = 1'b0;
        res_q.delete();
        hit_q.delete();
        win_q.delete();
        m_state    = 0;
        m_cnt      = 0;
        m_hb       = 0;
        m_last_cls = 0;
        hits_seen  = 0;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_overall", 64'(overall_result), 64'd0);
        check_eq("rst_window_full", 64'(window_full), 64'd0);
        check_eq("rst_hit_valid", 64'(hit_valid), 64'd0);
        check_eq("rst_hit_bin", 64'(hit_bin), 64'd0);
    endtask

    // Output monitor: pops expectations when their cycle arrives.
    always @(negedge clk) begin
        if (!reset) begin
            if (res_q.size() > 0 && res_q[0].cyc <= cyc) begin
                check_eq("result", 64'(result), 64'(res_q[0].val));
                void'(res_q.pop_front());
            end
            if (hit_valid) hits_seen++;
            if (hit_q.size() > 0 && hit_q[0].cyc <= cyc) begin
                check_eq("hit_valid", 64'(hit_valid), 64'd1);
                check_eq("hit_bin", 64'(hit_bin), 64'(hit_q[0].val));
                void'(hit_q.pop_front());
            end else if (hit_valid) begin
                check_eq("hit_unexpected", 64'(hit_valid), 64'd0);
            end
        end
    end

    initial begin
        reset   = 1'b1;
        advance = 1'b0;
        foreach (power[i]) power[i] = '0;
        repeat (3) @(negedge clk);
        do_reset();

        // Back-to-back strobes on bin 2, with exact pipeline latencies
        tone(2, 16, 0);
        @(negedge clk);
        advance = 1'b0;
        check_eq("t1_full_at_t1", 64'(window_full), 64'd0);
        @(negedge clk);
        check_eq("t1_full_at_t2", 64'(window_full), 64'd1);
        check_eq("t1_overall_at_t2", 64'(overall_result), 64'd0);
        @(negedge clk);
        check_eq("t1_overall_at_t3", 64'(overall_result), 64'd3);
        repeat (4) @(negedge clk);
        check_eq("t1_hit_bin", 64'(hit_bin), 64'd3);
        check_eq("t1_hits", 64'(hits_seen), 64'd1);

        // Dominance margin boundary
        frame(800, 100, 0, 0, 0, GAP);
        frame(808, 100, 0, 0, 1, GAP);

        // Hold-off: no retrigger inside 32 pushes, retrigger after
        do_reset();
        tone(0, 16, GAP);
        check_eq("ho_first_hit", 64'(hits_seen), 64'd1);
        silence(16);
        tone(0, 16, GAP);
        check_eq("ho_no_retrigger", 64'(hits_seen), 64'd1);
        silence(16);
        tone(0, 16, GAP);
        check_eq("ho_retrigger", 64'(hits_seen), 64'd2);

        // REARM on a different bin without silence
        tone(0, 40, GAP);
        tone(3, 16, GAP);
        check_eq("rearm_hits", 64'(hits_seen), 64'd3);
        check_eq("rearm_hit_bin", 64'(hit_bin), 64'd4);

        // Vote tie resolves to the lowest index
        do_reset();
        tone(0, 8, GAP);
        tone(2, 8, GAP);
        check_eq("tie_overall", 64'(overall_result), 64'd1);
        check_eq("tie_hit_bin", 64'(hit_bin), 64'd1);

        // Reset while holding with a full window
        do_reset();
        tone(1, 15, GAP);
        check_eq("post_rst_overall", 64'(overall_result), 64'd0);
        check_eq("post_rst_full", 64'(window_full), 64'd0);
        check_eq("post_rst_hits", 64'(hits_seen), 64'd0);

        repeat (10) @(negedge clk);
        check_eq("res_q_drained", 64'(res_q.size()), 64'd0);
        check_eq("hit_q_drained", 64'(hit_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bin_vote_detector.md
# bin_vote_detector

Parametrised N-bin tone detector with a sliding-window majority vote and onset (hit) events. Sits after the per-bin Goertzel power stage. Each `advance` frame it classifies the bin powers as silence or one dominant bin, and votes over the last WINDOW frames. It emits a single-cycle hit pulse per struck note, with a hold-off so ringing cannot retrigger.

## Interface
- NUM_BINS, 4, number of power bins (2..7)
- POWER_WIDTH, 64, signed power word width
- SHIFT_LOG2, 3, dominance margin: bin must exceed every other bin by 2^SHIFT_LOG2
- WINDOW, 16, vote window depth in frames (>=2)
- VOTE_THRESH, 8, minimum votes for a window decision (1..WINDOW)
- HOLDOFF, 32, frames after a hit during which no hit may fire (>=1)
- CLS_W, derived $clog2(NUM_BINS+1), class code width

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- advance  in  1  one-cycle strobe: power words valid this cycle
- power  in  NUM_BINS x POWER_WIDTH signed  bin powers, index 0..NUM_BINS-1
- result  out  CLS_W  per-frame class: 0 silence, i+1 = bin i dominant
- overall_result  out  CLS_W  windowed vote decision, same encoding
- window_full  out  1  WINDOW frames collected since reset
- hit_valid  out  1  one-cycle onset pulse
- hit_bin  out  CLS_W  class of hit, held until next hit

## Operation
- Classification, on advance: bin i is dominant iff (power[i] >>> SHIFT_LOG2) > power[j] for all j != i. Use an arithmetic shift and a signed compare. At most one bin can qualify; if none, class 0.
- Vote window: a FIFO shift register of WINDOW class codes, with one count per class, each $clog2(WINDOW+1) bits.
- Per pushed frame, the newest class count is incremented and the evicted (oldest) class count is decremented.
- Eviction occurs only when the window is full. If new == evicted, counts are unchanged.
- The fill counter saturates at WINDOW. window_full = (fill == WINDOW).
- Decision: overall_result = the lowest-index bin whose count >= VOTE_THRESH, else 0. It is forced to 0 while !window_full. Silence count never produces a nonzero decision.
- Hit FSM states:
  - IDLE: on overall_result != 0, pulse hit_valid, load hit_bin = overall_result, load hold counter = HOLDOFF, go to HOLD.
  - HOLD: decrement the counter once per pushed frame. At 0, go to REARM.
  - REARM: overall_result == 0 → IDLE. overall_result != 0 and != hit_bin → hit as in IDLE. Equal → stay.
- Reset at any time clears the result, window, counts, fill, decision, hold counter and FSM (IDLE). In-flight frames are discarded.

## Timing
- Reset values: result=0, overall_result=0, window_full=0, hit_valid=0, hit_bin=0.
- advance sampled at cycle t; result valid from t+1.
- Window push and counts update at t+2.
- overall_result updates at t+3; hit_valid asserts at t+4. Total latency advance→hit_valid = 4 cycles.
- Fully pipelined: advance may assert every cycle. Every strobe is classified and pushed, with no drops.
- result holds between strobes. overall_result re-evaluates every cycle from the counts.
- HOLD counts pushes, not cycles. With advance idle, HOLD persists indefinitely.
- hit_valid is high for exactly one cycle per hit. The FSM never fires two hits in consecutive cycles.
- The WINDOW-th push sets window_full in the same cycle the counts reflect that push.

## Structure
- Package bin_vote_pkg holds:
  - class constant CLS_SILENCE = 0;
  - hit FSM enum {IDLE, HOLD, REARM};
  - cls_width(n) function returning $clog2(n+1).
- Sub-module vote_window holds the FIFO, per-class counters, fill counter and the decision compare. It is instantiated once.
- Top level holds the classifier, the strobe delay pipe and the hit FSM.

## Test plan
- Defaults, bin 2 power = 1000, others = 100, 16 strobes: result = 3 from the first frame+1. window_full at push 16. overall_result = 3. One hit_valid with hit_bin = 3, 4 cycles after the 16th advance.
- Margin boundary: bin 0 = 800, bin 1 = 100 → class 0, since 100 > 100 is false. Bin 0 = 808 → class 1.
- Hold-off: hit on bin 1, then 16 frames silence + 16 frames bin 1 within 32 pushes → no second hit. The same sequence after 32 pushes → a second hit.
- REARM change: hit bin 1, sustain past HOLDOFF, switch to bin 4 for 16 frames → hit_bin = 4 without passing through silence.
- Vote tie: window of 8×bin1 + 8×bin3, VOTE_THRESH = 8 → overall_result = 1 (lowest index).
- Mid-run reset asserted during HOLD with a full window: next cycle all outputs 0, window_full = 0. 15 further bin-2 frames → no decision and no hit.
